// File: rtl/bw_seq_mult_ctrl_pkg.sv
// Shared types and helpers for the sequential Baugh-Wooley multiplier.
// Row and constant generators work on a wide vector; callers truncate to BW.
package bw_seq_mult_ctrl_pkg;

  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Partial-product row j: a & b_j, with the sign-position bits inverted (Baugh-Wooley).
  function automatic logic [MAXW-1:0] pp_row(input logic [MAXW-1:0] a, input logic b_bit,
                                             input int j, input int bw);
    logic [MAXW-1:0] top_s;
    logic [MAXW-1:0] keep_s;
    logic [MAXW-1:0] inv_s;
    top_s  = MAXW'(1) << (bw - 1);
    keep_s = (top_s << 1) - MAXW'(1);
    if (j == bw - 1) begin
      inv_s = top_s - MAXW'(1);
    end else begin
      inv_s = top_s;
    end
    return ((a & {MAXW{b_bit}}) ^ inv_s) & keep_s;
  endfunction

  // Added to the high half: 2^(bw-1) + 1, i.e. 2^(2bw-1) + 2^bw on the full product.
  function automatic logic [MAXW-1:0] fix_const(input int bw);
    return (MAXW'(1) << (bw - 1)) | MAXW'(1);
  endfunction

endpackage

// File: rtl/bw_seq_mult_ctrl_row_adder.sv
// BW-bit ripple-carry adder built from full-adder cells; shared by every row
// and by the final sign-correction add.
module bw_row_adder #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          cin,
  output logic [BW-1:0] sum,
  output logic          cout
);

  logic [BW:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < BW; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[BW];

endmodule

// File: rtl/bw_seq_mult_ctrl.sv
// Sequential signed BWxBW Baugh-Wooley multiplier: one partial-product row per
// cycle through a shared row adder, then one sign-correction add.
module bw_seq_mult_ctrl
  import bw_seq_mult_ctrl_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   a_in,
  input  logic [BW-1:0]   b_in,
  input  logic            abort,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*BW-1:0] product
);

  localparam int CW = $clog2(BW);
  localparam logic [CW-1:0] J_LAST = CW'(BW - 1);

  state_t            state_r;
  logic [BW-1:0]     a_r;
  logic [BW-1:0]     b_r;
  logic [BW-1:0]     hi_r;
  logic [BW-1:0]     lo_r;
  logic [CW-1:0]     j_r;
  logic              in_ready_r;
  logic              busy_r;
  logic              out_valid_r;
  logic [2*BW-1:0]   product_r;

  logic [BW-1:0]     add_b_s;
  logic [BW-1:0]     sum_s;
  logic              cout_s;

  // Adder operand select: current partial-product row, or the sign-correction constant.
  always_comb begin
    add_b_s = '0;
    if (state_r == ST_FIX) begin
      add_b_s = BW'(fix_const(BW));
    end else begin
      add_b_s = BW'(pp_row(MAXW'(a_r), b_r[j_r], int'(j_r), BW));
    end
  end

  bw_row_adder #(.BW(BW)) u_row_adder (
    .a    (hi_r),
    .b    (add_b_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Control FSM plus datapath registers; all handshake outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      hi_r        <= '0;
      lo_r        <= '0;
      j_r         <= '0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      product_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // abort in IDLE blocks acceptance of the offered operands
          if (!abort && in_valid) begin
            a_r        <= a_in;
            b_r        <= b_in;
            hi_r       <= '0;
            lo_r       <= '0;
            j_r        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_ROW;
          end
        end
        ST_ROW: begin
          if (abort) begin
            j_r        <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            hi_r <= {cout_s, sum_s[BW-1:1]};
            lo_r <= {sum_s[0], lo_r[BW-1:1]};
            if (j_r == J_LAST) begin
              j_r     <= '0;
              state_r <= ST_FIX;
            end else begin
              j_r <= j_r + CW'(1);
            end
          end
        end
        ST_FIX: begin
          if (abort) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            hi_r        <= sum_s;
            product_r   <= {sum_s, lo_r};
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready || abort) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          j_r         <= '0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;

endmodule

// File: tb/tb_bw_seq_mult_ctrl.sv
// Self-checking bench for bw_seq_mult_ctrl (BW=8): directed corner cases,
// randomized operands against an integer-arithmetic reference, and a scoreboard.
module tb_bw_seq_mult_ctrl;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a_in = 8'h00;
  logic [7:0]  b_in = 8'h00;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [15:0] product;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  int          acc_q[$];

  always #5 clk = ~clk;

  bw_seq_mult_ctrl #(.BW(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa * sb);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepted operand pairs, compare every delivered product.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready && !abort) begin
      exp_q.push_back(model_mul(a_in, b_in));
      acc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_output", 32'd1, 32'd0);
      else chk("sb_product", product, exp_q.pop_front());
    end else if (abort && (busy || out_valid)) begin
      exp_q.delete();
    end
  end

  always @(negedge rst_n) exp_q.delete();

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input logic [15:0] exp);
    int n;
    int lat;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s_accept", tag), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s_latency", tag), lat, 10);
    chk($sformatf("%s_product", tag), product, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_hold_product", tag), product, exp);
      chk($sformatf("%s_hold_valid", tag), out_valid, 1);
      chk($sformatf("%s_hold_in_ready", tag), in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("%s_idle_in_ready", tag), in_ready, 1);
    chk($sformatf("%s_idle_out_valid", tag), out_valid, 0);
  endtask

  initial begin
    int seen;
    int base;
    int n;
    logic [7:0] ra;
    logic [7:0] rb;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("m3x5", 8'd3, 8'd5, 0, 16'h000F);
    run_op("mn128xn128", 8'h80, 8'h80, 0, 16'h4000);
    run_op("mn128x127", 8'h80, 8'h7F, 1, 16'hC080);
    run_op("mn1xn1", 8'hFF, 8'hFF, 0, 16'h0001);
    run_op("m0xn77", 8'h00, 8'hB3, 0, 16'h0000);
    run_op("m7xn9_bp", 8'd7, 8'hF7, 5, 16'hFFC1);

    // abort in IDLE wins over in_valid
    a_in = 8'd5; b_in = 8'd5; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_in_ready", in_ready, 1);
    chk("idle_abort_busy", busy, 0);

    // abort during the fourth ROW cycle
    a_in = 8'd3; b_in = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy_before", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    seen = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    run_op("m12x12", 8'd12, 8'd12, 0, 16'h0090);

    // asynchronous reset in the middle of ROW
    a_in = 8'd9; b_in = 8'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_product", product, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst", 8'h9C, 8'd3, 0, 16'hFED4);

    // randomized single operations with random backpressure
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op("rand", ra, rb, $urandom_range(0, 2), model_mul(ra, rb));
    end

    // back-to-back with out_ready tied high; operands churn every cycle
    base = acc_q.size();
    out_ready = 1'b1;
    in_valid = 1'b1;
    n = 0;
    while (acc_q.size() < base + 60 && n < 2000) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_accept_count", acc_q.size(), base + 60);
    repeat (15) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = base + 1; i < acc_q.size(); i++) begin
      chk("b2b_spacing", acc_q[i] - acc_q[i - 1], 11);
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
